mu0_memory: RTL
===============

// Module: mu0_memory
// PURPOSE
//  Memory-side responder for the Mu0 processor bus (mem_rq / rnw / a_out / databus).
//  Holds a 4K x 16 word store that the processor reads and writes during execution.
//  A byte-stream boot loader fills the store while the processor is held in reset.
//  One address is a memory-mapped output register for observing results.
// PARAMETERS
//  ADDR     12       processor address width
//  DATA     16       data word width
//  DEPTH    4096     number of words; equals 2**ADDR
//  LD_BASE  12'h000  first word address written by the loader
//  IO_ADDR  12'hFFF  address of the memory-mapped output register
// PORTS
//  clk       in     1     system clock, rising edge
//  rst_n     in     1     asynchronous reset, active-low
//  mem_rq    in     1     processor memory request
//  rnw       in     1     1 = read, 0 = write; valid while mem_rq = 1
//  a_out     in     ADDR  processor word address
//  databus   inout  DATA  shared data bus; this block drives it only on reads
//  ld_valid  in     1     loader byte valid
//  ld_byte   in     8     loader byte; high byte of each word comes first
//  ld_last   in     1     marks the final byte of the image; qualified by ld_valid
//  ld_ready  out    1     loader can accept a byte
//  reload    in     1     1-cycle request to re-enter load mode
//  cpu_rst   out    1     active-high reset to the processor's rst input
//  io_out    out    DATA  memory-mapped output register
//  io_stb    out    1     1-cycle pulse when io_out is written
//  ld_err    out    1     sticky flag: loader address wrapped, or odd-length image
// BEHAVIOUR
//  Reset (rst_n = 0, async):
//    state = LD_HI; ld_ptr = LD_BASE; cpu_rst = 1; io_out = 0; io_stb = 0; ld_err = 0.
//    databus is high-Z. Word store contents are not cleared.
//  FSM states: LD_HI, LD_LO, RUN.
//    ld_ready = (state != RUN). A byte transfers when ld_valid & ld_ready.
//    LD_HI + transfer: latch hi <= ld_byte.
//      If ld_last: write mem[ld_ptr] <= {ld_byte, 8'h00}, set ld_err, go to RUN.
//      Otherwise go to LD_LO.
//    LD_LO + transfer: write mem[ld_ptr] <= {hi, ld_byte}; ld_ptr <= ld_ptr + 1.
//      If ld_last go to RUN, else go to LD_HI.
//    No transfer: hold state, hi and ld_ptr.
//    ld_ptr wraps from DEPTH-1 to 0. A write at DEPTH-1 that is not the last byte sets ld_err.
//    RUN + reload: go to LD_HI; ld_ptr = LD_BASE; cpu_rst = 1 on the next cycle.
//      ld_err and io_out keep their values.
//    reload in LD_HI or LD_LO is ignored. ld_valid in RUN is ignored.
//  cpu_rst is registered: it is 1 in LD_HI and LD_LO, and drops on the first clock edge
//    after entering RUN. The processor therefore starts at pc = 0 one cycle after the last byte.
//  Processor bus, RUN state only (loader states ignore mem_rq and keep databus high-Z):
//    Read (mem_rq & rnw): asynchronous, zero-latency.
//      databus = mem[a_out], or io_out when a_out == IO_ADDR, in the same cycle.
//      The processor latches the value on the next rising edge.
//    Write (mem_rq & !rnw): at the rising edge, mem[a_out] <= databus.
//      If a_out == IO_ADDR: io_out <= databus and io_stb = 1 for one cycle; mem is not written.
//    Otherwise databus is high-Z. The block never drives the bus while rnw = 0.
//  Reset in the middle of a load abandons the partial word: hi is discarded and ld_ptr = LD_BASE.
// TESTING
//  1. Load bytes 12,34,56,78 (last on 78), one per cycle -> mem[0]=16'h1234, mem[1]=16'h5678;
//     ld_ready=0 and cpu_rst=0 one cycle after the 78 transfer; ld_err=0.
//  2. In RUN, read at a_out=1 -> databus=16'h5678 in the same cycle.
//     With mem_rq=0 -> databus=Z.
//  3. Write 16'hBEEF to IO_ADDR -> io_out=16'hBEEF, io_stb high exactly 1 cycle, mem[FFF] unchanged.
//     Read of FFF returns 16'hBEEF.
//  4. Image of 3 bytes AA,BB,CC (last on CC) -> mem[1]=16'hCC00, ld_err=1.
//     ld_valid gaps between bytes leave the result unchanged.
//  5. Drop rst_n mid-word after byte 12 -> ld_ptr=0, state LD_HI, cpu_rst=1.
//     Next load writes mem[0] from new bytes.
//  6. reload pulse in RUN -> cpu_rst=1 next cycle, ld_ready=1.
//     Loading 8193 bytes wraps ld_ptr to 0 and sets ld_err.

Source files
------------

// File: rtl/mu0_memory.sv
// Memory-side responder for the Mu0 bus: a 4K x 16 word store, a byte-stream boot loader
// that fills it while the processor is held in reset, and a memory-mapped output register.
module mu0_memory #(
  parameter int              ADDR    = 12,
  parameter int              DATA    = 16,
  parameter int              DEPTH   = 4096,
  parameter logic [ADDR-1:0] LD_BASE = 12'h000,
  parameter logic [ADDR-1:0] IO_ADDR = 12'hFFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_rq,
  input  logic            rnw,
  input  logic [ADDR-1:0] a_out,
  inout  wire  [DATA-1:0] databus,
  input  logic            ld_valid,
  input  logic [7:0]      ld_byte,
  input  logic            ld_last,
  output logic            ld_ready,
  input  logic            reload,
  output logic            cpu_rst,
  output logic [DATA-1:0] io_out,
  output logic            io_stb,
  output logic            ld_err
);

  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

  typedef enum logic [1:0] {
    LD_HI = 2'd0,
    LD_LO = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ADDR-1:0] ld_ptr_q, ld_ptr_d;
  logic [7:0]      hi_q, hi_d;
  logic            cpu_rst_q, cpu_rst_d;
  logic [DATA-1:0] io_out_q, io_out_d;
  logic            io_stb_q, io_stb_d;
  logic            ld_err_q, ld_err_d;

  logic [DATA-1:0] mem_q [DEPTH];
  logic            mem_we;
  logic [ADDR-1:0] mem_wa;
  logic [DATA-1:0] mem_wd;

  logic            bus_oe;
  logic [DATA-1:0] rd_data;

  always_comb begin
    state_d  = state_q;
    ld_ptr_d = ld_ptr_q;
    hi_d     = hi_q;
    ld_err_d = ld_err_q;
    io_out_d = io_out_q;
    io_stb_d = 1'b0;
    mem_we   = 1'b0;
    mem_wa   = ld_ptr_q;
    mem_wd   = {hi_q, ld_byte};
    case (state_q)
      LD_HI: begin
        if (ld_valid) begin
          hi_d = ld_byte;
          if (ld_last) begin
            // Odd-length image: the lone high byte becomes a padded word.
            mem_we   = 1'b1;
            mem_wd   = {ld_byte, 8'h00};
            ld_err_d = 1'b1;
            state_d  = RUN;
          end else begin
            state_d = LD_LO;
          end
        end
      end
      LD_LO: begin
        if (ld_valid) begin
          mem_we   = 1'b1;
          ld_ptr_d = ld_ptr_q + 1'b1;
          if ((ld_ptr_q == LAST_ADDR) && !ld_last) begin
            ld_err_d = 1'b1;
          end
          state_d = ld_last ? RUN : LD_HI;
        end
      end
      RUN: begin
        if (reload) begin
          state_d  = LD_HI;
          ld_ptr_d = LD_BASE;
        end
        if (mem_rq && !rnw) begin
          if (a_out == IO_ADDR) begin
            io_out_d = databus;
            io_stb_d = 1'b1;
          end else begin
            mem_we = 1'b1;
            mem_wa = a_out;
            mem_wd = databus;
          end
        end
      end
      default: begin
        state_d = LD_HI;
      end
    endcase
    // Registered so the processor leaves reset exactly when RUN is entered.
    cpu_rst_d = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LD_HI;
      ld_ptr_q  <= LD_BASE;
      hi_q      <= 8'h00;
      cpu_rst_q <= 1'b1;
      io_out_q  <= '0;
      io_stb_q  <= 1'b0;
      ld_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_ptr_q  <= ld_ptr_d;
      hi_q      <= hi_d;
      cpu_rst_q <= cpu_rst_d;
      io_out_q  <= io_out_d;
      io_stb_q  <= io_stb_d;
      ld_err_q  <= ld_err_d;
    end
  end

  // Word store is deliberately not reset so an image survives a processor restart.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign bus_oe  = (state_q == RUN) && mem_rq && rnw;
  assign rd_data = (a_out == IO_ADDR) ? io_out_q : mem_q[a_out];
  assign databus = bus_oe ? rd_data : {DATA{1'bz}};

  assign ld_ready = (state_q != RUN);
  assign cpu_rst  = cpu_rst_q;
  assign io_out   = io_out_q;
  assign io_stb   = io_stb_q;
  assign ld_err   = ld_err_q;

endmodule
